// File: rtl/pio_hash_bridge.sv
// PIO-to-hash-core bridge: software loads a 16-word message block over the
// Nios PIO handshake, starts the SHA-1 core, and reads back the 160-bit digest.
// Control inputs are level signals from software. They are synchronized and
// edge-detected, and every action is registered the cycle after detection.
module pio_hash_bridge #(
    parameter int MSG_WORDS   = 16,
    parameter int DIG_WORDS   = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [7:0]              pio_address,
    input  logic [31:0]             pio_write_data,
    input  logic [3:0]              pio_ctrl_in,
    output logic [3:0]              pio_ctrl_out,
    output logic [31:0]             pio_read_data,
    output logic                    core_start,
    output logic [31:0]             core_data,
    output logic                    core_valid,
    input  logic                    core_ready,
    input  logic [32*DIG_WORDS-1:0] core_digest,
    input  logic                    core_digest_valid
);

    localparam int IDXW = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
    localparam int DIGW = (DIG_WORDS > 1) ? $clog2(DIG_WORDS) : 1;
    localparam logic [7:0]      MSG_END   = 8'(MSG_WORDS);
    localparam logic [7:0]      DIG_BASE  = 8'h10;
    localparam logic [7:0]      DIG_END   = 8'h10 + 8'(DIG_WORDS);
    localparam logic [7:0]      STAT_ADDR = 8'h20;
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(MSG_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    logic [3:0]      sync_q [SYNC_STAGES];
    logic [3:0]      sync_d [SYNC_STAGES];
    logic [3:0]      prev_q, prev_d;
    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [31:0]     msg_q [MSG_WORDS];
    logic [31:0]     msg_d [MSG_WORDS];
    logic [31:0]     dig_q [DIG_WORDS];
    logic [31:0]     dig_d [DIG_WORDS];
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            core_start_q, core_start_d;
    logic            core_valid_q, core_valid_d;
    logic [31:0]     core_data_q, core_data_d;

    logic [3:0]      sync_s;
    logic [3:0]      rise_s;
    logic            wr_ev_s, rd_ev_s, st_ev_s, clr_ev_s;
    logic            msg_hit_s, abort_s, err_set_s;
    logic [IDXW-1:0] widx_s;
    logic [DIGW-1:0] didx_s;
    logic [31:0]     rd_sel_s;

    // Rising-edge events: synchronized level high while its previous value was low.
    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign rise_s    = sync_s & ~prev_q;
    assign wr_ev_s   = rise_s[0];
    assign rd_ev_s   = rise_s[1];
    assign st_ev_s   = rise_s[2];
    assign clr_ev_s  = rise_s[3];
    assign msg_hit_s = (pio_address < MSG_END);
    assign widx_s    = pio_address[IDXW-1:0];
    assign didx_s    = pio_address[DIGW-1:0] - DIG_BASE[DIGW-1:0];
    assign abort_s   = clr_ev_s & busy_q;
    assign err_set_s = (wr_ev_s & msg_hit_s & busy_q) | (wr_ev_s & rd_ev_s) | (st_ev_s & busy_q);

    // Synchronizer chain and previous-value flop for the software control levels.
    always_comb begin
        sync_d[0] = pio_ctrl_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_s;
    end

    // Register read mux: message words, digest words, status, zero elsewhere.
    always_comb begin
        rd_sel_s = 32'h0000_0000;
        if (msg_hit_s) begin
            rd_sel_s = msg_q[widx_s];
        end else if ((pio_address >= DIG_BASE) && (pio_address < DIG_END)) begin
            rd_sel_s = dig_q[didx_s];
        end else if (pio_address == STAT_ADDR) begin
            rd_sel_s = {29'h0, err_q, done_q, busy_q};
        end else begin
            rd_sel_s = 32'h0000_0000;
        end
    end

    // Next-state logic: PIO handshake, sticky flags and the block-streaming FSM.
    always_comb begin
        msg_d        = msg_q;
        dig_d        = dig_q;
        state_d      = state_q;
        idx_d        = idx_q;
        ack_d        = ack_q;
        busy_d       = busy_q;
        done_d       = clr_ev_s ? 1'b0 : done_q;
        err_d        = clr_ev_s ? 1'b0 : (err_q | err_set_s);
        rdata_d      = rdata_q;
        core_start_d = 1'b0;
        core_valid_d = core_valid_q;
        core_data_d  = core_data_q;

        // A simultaneous RD is dropped in favour of the WR (and flagged via err_set_s).
        if (wr_ev_s) begin
            ack_d = 1'b1;
            if (msg_hit_s && !busy_q) begin
                msg_d[widx_s] = pio_write_data;
            end else begin
                msg_d[widx_s] = msg_q[widx_s];
            end
        end else if (rd_ev_s) begin
            ack_d   = 1'b1;
            rdata_d = rd_sel_s;
        end else if (!sync_s[0] && !sync_s[1]) begin
            ack_d = 1'b0;
        end else begin
            ack_d = ack_q;
        end

        if (abort_s) begin
            state_d      = ST_IDLE;
            idx_d        = '0;
            busy_d       = 1'b0;
            core_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (st_ev_s) begin
                        state_d      = ST_SEND;
                        idx_d        = '0;
                        busy_d       = 1'b1;
                        done_d       = 1'b0;
                        core_start_d = 1'b1;
                        core_valid_d = 1'b1;
                        core_data_d  = msg_d[0];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (core_valid_q && core_ready) begin
                        if (idx_q == IDX_LAST) begin
                            core_valid_d = 1'b0;
                            state_d      = ST_WAIT;
                        end else begin
                            idx_d       = idx_q + IDXW'(1);
                            core_data_d = msg_q[idx_q + IDXW'(1)];
                        end
                    end else begin
                        state_d = ST_SEND;
                    end
                end
                ST_WAIT: begin
                    if (core_digest_valid) begin
                        for (int i = 0; i < DIG_WORDS; i++) begin
                            dig_d[i] = core_digest[32*(DIG_WORDS-1-i) +: 32];
                        end
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    core_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers; reset discards everything, including an in-flight block.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'h0;
            end
            for (int i = 0; i < MSG_WORDS; i++) begin
                msg_q[i] <= 32'h0000_0000;
            end
            for (int i = 0; i < DIG_WORDS; i++) begin
                dig_q[i] <= 32'h0000_0000;
            end
            prev_q       <= 4'h0;
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            core_start_q <= 1'b0;
            core_valid_q <= 1'b0;
            core_data_q  <= 32'h0000_0000;
        end else begin
            sync_q       <= sync_d;
            msg_q        <= msg_d;
            dig_q        <= dig_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            core_start_q <= core_start_d;
            core_valid_q <= core_valid_d;
            core_data_q  <= core_data_d;
        end
    end

    assign pio_ctrl_out  = {err_q, done_q, busy_q, ack_q};
    assign pio_read_data = rdata_q;
    assign core_start    = core_start_q;
    assign core_valid    = core_valid_q;
    assign core_data     = core_data_q;

endmodule
